// File: rtl/rv32_mem_pkg.sv
// Shared types and defaults for the RV32 instruction/data memory-port arbiter.
package rv32_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam logic [3:0] BE_FULL = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arbState_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (fetch/data) and memory-side signals of the arbiter, grouped as one bundle.
interface mem_port_arbiter_if
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    // Handshake: IReq/DReq are held with stable payload until the matching one-cycle
    // IReady/DReady strobe; MemReq is held with stable payload until MemAck (one cycle,
    // only while MemReq=1) or until the arbiter aborts on timeout.
    logic              IReq;
    logic [ADDR_W-1:0] IAddr;
    logic              IReady;
    logic [DATA_W-1:0] IRdata;

    logic              DReq;
    logic              DWE;
    logic [ADDR_W-1:0] DAddr;
    logic [DATA_W-1:0] DWdata;
    logic [3:0]        DByteEn;
    logic              DReady;
    logic [DATA_W-1:0] DRdata;

    logic              BusErr;

    logic              MemReq;
    logic              MemWE;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWdata;
    logic [3:0]        MemBE;
    logic [DATA_W-1:0] MemRdata;
    logic              MemAck;

    modport slave (
        input  IReq, IAddr, DReq, DWE, DAddr, DWdata, DByteEn, MemRdata, MemAck,
        output IReady, IRdata, DReady, DRdata, BusErr,
        output MemReq, MemWE, MemAddr, MemWdata, MemBE
    );

    modport master (
        output IReq, IAddr, DReq, DWE, DAddr, DWdata, DByteEn, MemRdata, MemAck,
        input  IReady, IRdata, DReady, DRdata, BusErr,
        input  MemReq, MemWE, MemAddr, MemWdata, MemBE
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Grant selection: data wins unless fetch has waited through MAX_STREAK data grants.
module mem_arb_pick #(
    parameter int MAX_STREAK = 4,
    parameter int STREAK_W   = 3
) (
    input  logic                iReq,
    input  logic                dReq,
    input  logic [STREAK_W-1:0] streak,
    output logic                grantI,
    output logic                grantD
);

    logic starved;

    assign starved = iReq && (streak == STREAK_W'(MAX_STREAK));
    assign grantD  = dReq && !starved;
    assign grantI  = iReq && !grantD;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory port, with anti-starvation streak
// limit and an ack timeout that completes the owner with BusErr.
module mem_port_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mem_port_arbiter_if.slave       bus,
    output arbState_t               dbgState,
    output logic [7:0]              dbgStreak
);

    localparam int STREAK_W = $clog2(MAX_STREAK + 1);
    localparam int TMO_W    = $clog2(TIMEOUT + 1);

    arbState_t           state;
    arbState_t           stateNext;
    logic [STREAK_W-1:0] streak;
    logic [TMO_W-1:0]    tmoCnt;
    logic                grantI;
    logic                grantD;
    logic                ackHit;
    logic                tmoHit;
    logic                done;

    logic                memReq;
    logic                memWE;
    logic [ADDR_W-1:0]   memAddr;
    logic [DATA_W-1:0]   memWdata;
    logic [3:0]          memBE;

    mem_arb_pick #(
        .MAX_STREAK (MAX_STREAK),
        .STREAK_W   (STREAK_W)
    ) uPick (
        .iReq   (bus.IReq),
        .dReq   (bus.DReq),
        .streak (streak),
        .grantI (grantI),
        .grantD (grantD)
    );

    // An ack landing on the final timeout cycle takes precedence over the abort.
    assign ackHit = (state != IDLE) && bus.MemAck;
    assign tmoHit = (state != IDLE) && !bus.MemAck && (tmoCnt == TMO_W'(TIMEOUT - 1));
    assign done   = ackHit || tmoHit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        bus.IReady = 1'b0;
        bus.IRdata = '0;
        bus.DReady = 1'b0;
        bus.DRdata = '0;
        bus.BusErr = tmoHit;
        case (state)
            IDLE: begin
                if (grantD) begin
                    stateNext = D_BUSY;
                end else if (grantI) begin
                    stateNext = I_BUSY;
                end
            end
            I_BUSY: begin
                bus.IReady = done;
                bus.IRdata = ackHit ? bus.MemRdata : '0;
                if (done) stateNext = IDLE;
            end
            D_BUSY: begin
                bus.DReady = done;
                bus.DRdata = ackHit ? bus.MemRdata : '0;
                if (done) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Memory-side fields are captured only at grant, so requester changes while busy are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memReq   <= 1'b0;
            memWE    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            memBE    <= '0;
            streak   <= '0;
            tmoCnt   <= '0;
        end else if (state == IDLE) begin
            tmoCnt <= '0;
            if (grantD) begin
                memReq   <= 1'b1;
                memWE    <= bus.DWE;
                memAddr  <= bus.DAddr;
                memWdata <= bus.DWdata;
                memBE    <= bus.DByteEn;
                if (bus.IReq && (streak != STREAK_W'(MAX_STREAK))) begin
                    streak <= streak + STREAK_W'(1);
                end
            end else if (grantI) begin
                memReq   <= 1'b1;
                memWE    <= 1'b0;
                memAddr  <= bus.IAddr;
                memWdata <= '0;
                memBE    <= BE_FULL;
                streak   <= '0;
            end
        end else if (done) begin
            memReq   <= 1'b0;
            memWE    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            memBE    <= '0;
        end else begin
            tmoCnt <= tmoCnt + TMO_W'(1);
        end
    end

    assign bus.MemReq   = memReq;
    assign bus.MemWE    = memWE;
    assign bus.MemAddr  = memAddr;
    assign bus.MemWdata = memWdata;
    assign bus.MemBE    = memBE;

    assign dbgState  = state;
    assign dbgStreak = 8'(streak);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester/memory driver processes, a negedge
// monitor that pops expected memory requests and completions, and directed scenarios.
module tb_mem_port_arbiter;
  import rv32_mem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 77;  // {streak[7:0], we, be[3:0], addr, wdata}
  localparam int RW = 67;  // {IReady, DReady, BusErr, IRdata, DRdata}

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    be;
  } d_item_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  arbState_t  dbg_state;
  logic [7:0] dbg_streak;

  mem_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .MAX_STREAK (4),
    .TIMEOUT    (255)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbgState  (dbg_state),
    .dbgStreak (dbg_streak)
  );

  // ---------------- scoreboard state ----------------
  logic [MW-1:0] exp_q[$];
  logic [RW-1:0] exp_rsp_q[$];
  logic [AW-1:0] i_q[$];
  d_item_t       d_q[$];
  logic [DW-1:0] mem_data_q[$];
  int            rise_cycs[$];
  int            ready_cycs[$];

  int n_checks = 0;
  int n_bad = 0;
  int cyc = 0;
  int hi_cnt = 0;
  int hi_at_ready = 0;
  int mem_lat = 1;
  bit mem_ack_en = 1'b1;
  bit stray_ack = 1'b0;
  bit i_done = 1'b0;
  bit d_done = 1'b0;
  logic prev_req = 1'b0;
  logic have_cur = 1'b0;
  logic [MW-1:0] cur_exp;
  logic [DW-1:0] rd[6];

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] mem_vec(input logic [7:0] stk, input logic we,
                                            input logic [3:0] be, input logic [AW-1:0] addr,
                                            input logic [DW-1:0] wd);
    return {stk, we, be, addr, (we ? wd : {DW{1'b0}})};
  endfunction

  function automatic logic [RW-1:0] rsp_vec(input logic is_d, input logic err,
                                            input logic [DW-1:0] rdv);
    return {!is_d, is_d, err, (is_d ? {DW{1'b0}} : rdv), (is_d ? rdv : {DW{1'b0}})};
  endfunction

  // ---------------- requester driver ----------------
  initial begin
    bus.IReq = 1'b0; bus.IAddr = '0;
    bus.DReq = 1'b0; bus.DWE = 1'b0; bus.DAddr = '0; bus.DWdata = '0; bus.DByteEn = '0;
    forever begin
      @(posedge clk); #1;
      if (i_done) begin void'(i_q.pop_front()); i_done = 1'b0; end
      if (d_done) begin void'(d_q.pop_front()); d_done = 1'b0; end
      bus.IReq  = (i_q.size() != 0);
      bus.IAddr = (i_q.size() != 0) ? i_q[0] : '0;
      bus.DReq  = (d_q.size() != 0);
      if (d_q.size() != 0) begin
        bus.DWE = d_q[0].we; bus.DAddr = d_q[0].addr;
        bus.DWdata = d_q[0].wdata; bus.DByteEn = d_q[0].be;
      end else begin
        bus.DWE = 1'b0; bus.DAddr = '0; bus.DWdata = '0; bus.DByteEn = '0;
      end
    end
  end

  // ---------------- memory responder ----------------
  initial begin
    int age;
    age = 0;
    bus.MemAck = 1'b0; bus.MemRdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.MemAck = 1'b0; bus.MemRdata = '0;
      if (bus.MemReq) begin
        if (mem_ack_en && age == mem_lat) begin
          bus.MemAck = 1'b1;
          if (mem_data_q.size() != 0) bus.MemRdata = mem_data_q.pop_front();
        end
        age++;
      end else begin
        age = 0;
        if (stray_ack) begin bus.MemAck = 1'b1; bus.MemRdata = 32'hBAD0BAD0; end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [RW-1:0] r_exp;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_req = 1'b0; have_cur = 1'b0; hi_cnt = 0;
      end else begin
        if (bus.MemReq && !prev_req) begin
          rise_cycs.push_back(cyc);
          hi_cnt = 0;
          if (exp_q.size() == 0) begin
            have_cur = 1'b0;
            check_eq("unexp_memreq", 80'(1), 80'(0));
          end else begin
            cur_exp = exp_q.pop_front();
            have_cur = 1'b1;
            check_eq("mem_req", 80'(mem_vec(dbg_streak, bus.MemWE, bus.MemBE, bus.MemAddr, bus.MemWdata)), 80'(cur_exp));
          end
        end else if (bus.MemReq && have_cur) begin
          check_eq("mem_hold", 80'(mem_vec(dbg_streak, bus.MemWE, bus.MemBE, bus.MemAddr, bus.MemWdata)), 80'(cur_exp));
        end
        if (bus.MemReq) hi_cnt++;
        if (bus.IReady || bus.DReady) begin
          ready_cycs.push_back(cyc);
          hi_at_ready = hi_cnt;
          have_cur = 1'b0;
          if (exp_rsp_q.size() == 0) begin
            check_eq("unexp_ready", 80'(1), 80'(0));
          end else begin
            r_exp = exp_rsp_q.pop_front();
            check_eq("rsp", 80'({bus.IReady, bus.DReady, bus.BusErr, bus.IRdata, bus.DRdata}), 80'(r_exp));
          end
          if (bus.IReady) i_done = 1'b1;
          if (bus.DReady) d_done = 1'b1;
        end else begin
          check_eq("idle_rsp", 80'({bus.BusErr, bus.IRdata, bus.DRdata}), 80'(0));
        end
        prev_req = bus.MemReq;
      end
    end
  end

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_rsp_q.size() != 0 || i_q.size() != 0 || d_q.size() != 0)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_drain"}, 80'(n < budget), 80'(1));
    repeat (2) @(negedge clk);
  endtask

  function automatic int gap(input int later, input int earlier);
    return later - earlier;
  endfunction

  // ---------------- scenarios ----------------
  initial begin
    d_item_t it;
    logic [DW-1:0] r1, r2, w;
    int n;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_mem", 80'({bus.MemReq, bus.MemWE, bus.MemBE, bus.MemAddr}), 80'(0));
    check_eq("reset_wdata", 80'(bus.MemWdata), 80'(0));
    check_eq("reset_rsp", 80'({bus.IReady, bus.DReady, bus.BusErr, bus.IRdata, bus.DRdata}), 80'(0));
    check_eq("reset_state", 80'({dbg_state, dbg_streak}), 80'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);

    // single fetch, ack two cycles after MemReq
    rise_cycs.delete(); ready_cycs.delete();
    mem_lat = 2;
    mem_data_q.push_back(32'h00500093);
    exp_q.push_back(mem_vec(8'd0, 1'b0, BE_FULL, 32'h100, '0));
    exp_rsp_q.push_back(rsp_vec(1'b0, 1'b0, 32'h00500093));
    i_q.push_back(32'h100);
    wait_drain("fetch", 50);
    check_eq("fetch_lat", 80'((ready_cycs.size() > 0 && rise_cycs.size() > 0) ? gap(ready_cycs[0], rise_cycs[0]) : -1), 80'(2));

    // contention: store wins, fetch follows after one idle cycle
    rise_cycs.delete(); ready_cycs.delete();
    mem_lat = 1;
    r1 = $urandom; r2 = $urandom;
    mem_data_q.push_back(r1); mem_data_q.push_back(r2);
    exp_q.push_back(mem_vec(8'd1, 1'b1, 4'h3, 32'h2000, 32'hDEADBEEF));
    exp_q.push_back(mem_vec(8'd0, 1'b0, BE_FULL, 32'h104, '0));
    exp_rsp_q.push_back(rsp_vec(1'b1, 1'b0, r1));
    exp_rsp_q.push_back(rsp_vec(1'b0, 1'b0, r2));
    it = '{we: 1'b1, addr: 32'h2000, wdata: 32'hDEADBEEF, be: 4'h3};
    d_q.push_back(it);
    i_q.push_back(32'h104);
    wait_drain("contend", 60);
    check_eq("contend_gap", 80'((ready_cycs.size() > 0 && rise_cycs.size() > 1) ? gap(rise_cycs[1], ready_cycs[0]) : -1), 80'(2));

    // starvation: four data grants, then fetch, then the remaining data item
    mem_lat = $urandom_range(0, 3);
    for (int k = 0; k < 6; k++) rd[k] = $urandom;
    for (int k = 0; k < 5; k++) begin
      it.we = 1'($urandom_range(0, 1));
      it.addr = {$urandom} & 32'hFFFF_FFFC;
      it.wdata = $urandom;
      it.be = 4'($urandom_range(1, 15));
      d_q.push_back(it);
      if (k == 4) begin
        exp_q.push_back(mem_vec(8'd0, 1'b0, BE_FULL, 32'h300, '0));
        exp_rsp_q.push_back(rsp_vec(1'b0, 1'b0, rd[4]));
        mem_data_q.push_back(rd[4]);
      end
      exp_q.push_back(mem_vec((k < 4) ? 8'(k + 1) : 8'd0, it.we, it.be, it.addr, it.wdata));
      exp_rsp_q.push_back(rsp_vec(1'b1, 1'b0, rd[(k < 4) ? k : 5]));
      mem_data_q.push_back(rd[(k < 4) ? k : 5]);
    end
    i_q.push_back(32'h300);
    wait_drain("starve", 200);
    check_eq("starve_streak", 80'(dbg_streak), 80'(0));

    // stray ack while idle is ignored
    stray_ack = 1'b1;
    @(negedge clk);
    check_eq("stray_ack", 80'({bus.IReady, bus.DReady, bus.BusErr, bus.MemReq}), 80'(0));
    stray_ack = 1'b0;
    @(negedge clk);
    check_eq("stray_state", 80'({dbg_state, bus.MemReq}), 80'(0));

    // fetch timeout: no ack at all
    mem_ack_en = 1'b0;
    exp_q.push_back(mem_vec(8'd0, 1'b0, BE_FULL, 32'h400, '0));
    exp_rsp_q.push_back(rsp_vec(1'b0, 1'b1, '0));
    i_q.push_back(32'h400);
    wait_drain("tmo", 400);
    check_eq("tmo_len", 80'(hi_at_ready), 80'(255));
    check_eq("tmo_drop", 80'({bus.MemReq, dbg_state}), 80'(0));
    mem_ack_en = 1'b1;

    // load acked on the very cycle the timeout would fire
    mem_lat = 254;
    r1 = $urandom;
    mem_data_q.push_back(r1);
    it = '{we: 1'b0, addr: 32'h500, wdata: $urandom, be: 4'h5};
    exp_q.push_back(mem_vec(8'd0, 1'b0, 4'h5, 32'h500, it.wdata));
    exp_rsp_q.push_back(rsp_vec(1'b1, 1'b0, r1));
    d_q.push_back(it);
    wait_drain("tmo_ack", 400);
    check_eq("tmo_ack_len", 80'(hi_at_ready), 80'(255));

    // reset while D_BUSY, then re-grant with requests still held
    mem_ack_en = 1'b0;
    w = $urandom;
    it = '{we: 1'b1, addr: 32'h600, wdata: w, be: BE_FULL};
    exp_q.push_back(mem_vec(8'd1, 1'b1, BE_FULL, 32'h600, w));
    d_q.push_back(it);
    i_q.push_back(32'h700);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    check_eq("rst_pre_grant", 80'(n < 20), 80'(1));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mem", 80'({bus.MemReq, bus.MemWE, bus.MemBE, bus.MemAddr}), 80'(0));
    check_eq("rst_wdata", 80'(bus.MemWdata), 80'(0));
    check_eq("rst_rsp", 80'({bus.IReady, bus.DReady, bus.BusErr, bus.IRdata, bus.DRdata}), 80'(0));
    check_eq("rst_state", 80'({dbg_state, dbg_streak}), 80'(0));
    r1 = $urandom; r2 = $urandom;
    exp_q.push_back(mem_vec(8'd1, 1'b1, BE_FULL, 32'h600, w));
    exp_q.push_back(mem_vec(8'd0, 1'b0, BE_FULL, 32'h700, '0));
    exp_rsp_q.push_back(rsp_vec(1'b1, 1'b0, r1));
    exp_rsp_q.push_back(rsp_vec(1'b0, 1'b0, r2));
    mem_data_q.push_back(r1); mem_data_q.push_back(r2);
    mem_lat = 1;
    mem_ack_en = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_no_early", 80'(bus.MemReq), 80'(0));
    @(negedge clk);
    check_eq("regrant", 80'({bus.MemReq, dbg_state}), 80'({1'b1, D_BUSY}));
    wait_drain("rst", 60);

    check_eq("final_empty", 80'(exp_q.size() + exp_rsp_q.size() + mem_data_q.size()), 80'(0));
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog got=running exp=finished");
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL expose the following parameters (name, default, meaning): ADDR_W 32 address width; DATA_W 32 data width; MAX_STREAK 4 consecutive data grants allowed while fetch waits; TIMEOUT 255 cycles to wait for MemAck before abort.
REQ-002 clk input 1: single clock, rising edge.
REQ-003 rst_n input 1: reset, asynchronous, active-low.
REQ-004 IReq input 1: fetch request, held until IReady.
REQ-005 IAddr input ADDR_W: fetch address.
REQ-006 IReady output 1: fetch completion strobe, one cycle.
REQ-007 IRdata output DATA_W: fetch data, valid with IReady.
REQ-008 DReq input 1: load/store request, held until DReady.
REQ-009 DWE input 1: 1 = store, 0 = load.
REQ-010 DAddr input ADDR_W: data address.
REQ-011 DWdata input DATA_W: store data.
REQ-012 DByteEn input 4: store byte enables.
REQ-013 DReady output 1: data completion strobe, one cycle.
REQ-014 DRdata output DATA_W: load data, valid with DReady.
REQ-015 BusErr output 1: timeout flag, qualified by IReady or DReady.
REQ-016 MemReq output 1: memory request, held until MemAck or abort.
REQ-017 MemWE output 1: memory write enable.
REQ-018 MemAddr output ADDR_W: memory address.
REQ-019 MemWdata output DATA_W: memory write data.
REQ-020 MemBE output 4: memory byte enables.
REQ-021 MemRdata input DATA_W: memory read data, valid with MemAck.
REQ-022 MemAck input 1: memory completion, one cycle, only while MemReq=1.

Function
REQ-023 The FSM SHALL have three states: IDLE, I_BUSY and D_BUSY.
REQ-024 In IDLE with at least one request, the block SHALL grant and register the Mem* fields from the winner, so that MemReq is asserted in the next cycle.
REQ-025 Priority SHALL be as follows: DReq wins over IReq, unless the streak counter equals MAX_STREAK and IReq=1, in which case IReq wins.
REQ-026 The streak counter SHALL increment on each data grant made while IReq=1, clear on any fetch grant, and saturate at MAX_STREAK.
REQ-027 A fetch grant SHALL set MemWE=0 and MemBE=4'hF; a data load SHALL set MemWE=0 and MemBE=DByteEn.
REQ-028 In a BUSY state, the Mem* outputs SHALL stay stable and ignore requester input changes.
REQ-029 On MemAck in a BUSY state, the owner's Ready SHALL be asserted combinationally in the same cycle with Rdata=MemRdata and BusErr=0, and the next state SHALL be IDLE.
REQ-030 The Ready and Rdata outputs of the non-owner SHALL be 0.
REQ-031 There SHALL be one mandatory IDLE cycle between transactions, so the minimum spacing is 2 cycles from MemAck to the next MemReq rise.
REQ-032 The timeout counter SHALL clear on grant and increment each BUSY cycle without MemAck.
REQ-033 When the timeout counter reaches TIMEOUT, the block SHALL drop MemReq, pulse the owner's Ready with BusErr=1 and Rdata=0, and return to IDLE.
REQ-034 A MemAck arriving in the same cycle as the timeout SHALL win, giving a normal completion.
REQ-035 A MemAck received in IDLE SHALL be ignored.
REQ-036 When IReq and DReq rise simultaneously, REQ-025 SHALL apply.
REQ-037 A requester dropping Req before its Ready SHALL be a protocol violation; the transaction SHALL still complete.

Reset
REQ-038 On rst_n=0, the block SHALL immediately enter IDLE, clear the streak and timeout counters, and drive all outputs to 0, including mid-transaction.
REQ-039 The first grant after reset SHALL be no earlier than the first rising clk edge after rst_n deasserts.

Structure
REQ-040 The state enum, the ADDR_W and DATA_W defaults and the BE_FULL constant SHALL live in shared package rv32_mem_pkg.
REQ-041 Grant selection (priority plus streak compare) SHALL be one combinational sub-module, mem_arb_pick; everything else SHALL be inline.

Verification
REQ-042 Single fetch: IReq=1 with IAddr=0x100, memory acks 2 cycles after MemReq -> MemAddr=0x100, MemWE=0, MemBE=F; IReady=1 in the ack cycle with IRdata=MemRdata=0x00500093.
REQ-043 Contention: IReq and DReq rise together, DWE=1, DAddr=0x2000, DWdata=0xDEADBEEF, DByteEn=0x3 -> data is served first with MemWE=1 and MemBE=3; fetch follows after a 1-cycle IDLE gap.
REQ-044 Starvation: IReq held with DReq continuously re-asserted, MAX_STREAK=4 -> the fifth grant goes to fetch and the streak counter clears.
REQ-045 Timeout: MemAck never asserted, TIMEOUT=255 -> MemReq drops after 255 BUSY cycles and the owner's Ready pulses with BusErr=1 and Rdata=0; ack and timeout in the same cycle -> normal completion with BusErr=0.
REQ-046 Reset mid-op: rst_n=0 while in D_BUSY -> all outputs are 0 in the same cycle; after release with DReq still 1, the block re-grants data with MemReq asserted 1 cycle later.
